phase_sequencer: RTL and testbench

//  Multi-cycle phase controller for the 16-bit core: steps one-hot phases P1..P5
//  (fetch, decode/read, execute, memory, writeback) and stalls on memory handshakes.

---
 rtl/phase_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_phase_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Phase controller for the 16-bit core: steps one-hot phases P1..P5, stalls on
// memory handshakes, gates IR/PC/flag/register writes, detects HLT and flags
// bus timeouts.
// Optional build macro PHASE_SKIP_EN: non-LD/ST instructions bypass P4.
module phase_sequencer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      instr,
    input  logic             mem_ack,
    output logic [4:0]       phase,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             szcv_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = 8;

`ifdef PHASE_SKIP_EN
    localparam bit SKIP_P4 = 1'b1;
`else
    localparam bit SKIP_P4 = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P2,
        S_P3,
        S_P4,
        S_P5,
        S_HALT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [4:0]        phase_d;
    logic              err_set;
    logic              err_clr;

    // Instruction decode
    logic       is_alu;
    logic       is_ld;
    logic       is_st;
    logic       is_mem;
    logic       is_hlt;
    logic [3:0] op3;
    logic       flags_ok;
    logic       wb_ok;
    logic       timeout;
    logic       unused_instr;

    assign op3          = instr[7:4];
    assign is_alu       = (instr[15:14] == 2'b11);
    assign is_ld        = (instr[15:14] == 2'b00);
    assign is_st        = (instr[15:14] == 2'b01);
    assign is_mem       = is_ld | is_st;
    assign is_hlt       = is_alu & (op3 == 4'b1111);
    assign flags_ok     = is_alu & (op3 != 4'b1100) & (op3 != 4'b1101) & (op3 != 4'b1111);
    assign wb_ok        = is_ld | (is_alu & (op3 != 4'b0101) & (op3 != 4'b1101) & (op3 != 4'b1111));
    assign timeout      = (wait_q == WAIT_W'(WAIT_MAX - 1));
    assign unused_instr = ^{instr[13:8], instr[3:0]};

    // Next-state, wait counter and strobe decode
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        szcv_we = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_P1;
            end
            S_P1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    wait_d  = '0;
                    state_d = S_P2;
                end else if (timeout) begin
                    err_set = 1'b1;
                    wait_d  = '0;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_P2: begin
                state_d = S_P3;
            end
            S_P3: begin
                szcv_we = flags_ok;
                if (is_hlt)                  state_d = S_HALT;
                else if (SKIP_P4 && !is_mem) state_d = S_P5;
                else                         state_d = S_P4;
            end
            S_P4: begin
                if (is_mem) begin
                    mem_req = 1'b1;
                    mem_we  = is_st;
                    if (mem_ack) begin
                        wait_d  = '0;
                        state_d = S_P5;
                    end else if (timeout) begin
                        err_set = 1'b1;
                        wait_d  = '0;
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = S_P5;
                end
            end
            S_P5: begin
                rf_we   = wb_ok;
                pc_we   = 1'b1;
                state_d = S_P1;
            end
            S_HALT: begin
                if (start) begin
                    err_clr = 1'b1;
                    state_d = S_P1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-hot phase image of the upcoming state
    always_comb begin
        phase_d = 5'b00000;
        case (state_d)
            S_P1:    phase_d = 5'b00001;
            S_P2:    phase_d = 5'b00010;
            S_P3:    phase_d = 5'b00100;
            S_P4:    phase_d = 5'b01000;
            S_P5:    phase_d = 5'b10000;
            default: phase_d = 5'b00000;
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            phase   <= '0;
            halted  <= 1'b0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            phase   <= phase_d;
            halted  <= (state_d == S_HALT);
            if (err_clr)      bus_err <= 1'b0;
            else if (err_set) bus_err <= 1'b1;
            if (pc_we) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized scoreboard bench for phase_sequencer: the driver issues random
// instructions and ack delays and queues the expected per-instruction profile;
// the monitor accumulates what the DUT does and compares at each retirement/halt.
module tb_phase_sequencer;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;
    localparam int          N_TX     = 250;
    localparam int          BUDGET   = 40000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [15:0]      instr;
    logic             mem_ack;
    logic [4:0]       phase;
    logic             mem_req;
    logic             mem_we;
    logic             ir_load;
    logic             szcv_we;
    logic             rf_we;
    logic             pc_we;
    logic             halted;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    phase_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_ack(mem_ack),
        .phase(phase), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
        .szcv_we(szcv_we), .rf_we(rf_we), .pc_we(pc_we), .halted(halted),
        .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // kind: 0 retired through P5, 1 halted by HLT, 2 bus timeout
    typedef struct {
        int p1; int p2; int p3; int p4; int p5;
        int szcv; int rf; int req; int we; int irl;
        int kind; int ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   completed = 0;
    bit   abort     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of unacked cycles before the ack; >= WAIT_MAX means never acked
    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0, 1, 2: return int'($urandom_range(0, 3));
            3:       return 14;
            4:       return ($urandom_range(0, 3) == 0) ? 15 : 0;
            5:       return int'($urandom_range(0, 13));
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] pick_instr();
        logic [1:0]  cls;
        logic [3:0]  op;
        logic [15:0] w;
        int          s;
        logic [3:0]  special [5];
        special[0] = 4'h0; special[1] = 4'h5; special[2] = 4'hC;
        special[3] = 4'hD; special[4] = 4'hF;
        cls = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
            s  = int'($urandom_range(0, 4));
            op = special[s];
        end else begin
            op = 4'($urandom_range(0, 15));
        end
        w = 16'($urandom);
        w[15:14] = cls;
        w[7:4]   = op;
        return w;
    endfunction

    // Expected behaviour of one instruction from the phase rules
    function automatic exp_t model(input logic [15:0] w, input int fd, input int dd, input int ret);
        exp_t e;
        bit   alu, ld, st;
        int   op;
        e = '{default: 0};
        e.ret = ret;
        alu = (w[15:14] == 2'b11);
        ld  = (w[15:14] == 2'b00);
        st  = (w[15:14] == 2'b01);
        op  = int'(w[7:4]);
        if (fd >= int'(WAIT_MAX)) begin
            e.p1 = int'(WAIT_MAX); e.req = int'(WAIT_MAX); e.kind = 2;
            return e;
        end
        e.p1 = fd + 1; e.req = fd + 1; e.irl = 1;
        e.p2 = 1; e.p3 = 1;
        if (alu && op == 15) begin
            e.kind = 1;
            return e;
        end
        e.szcv = (alu && op != 12 && op != 13) ? 1 : 0;
        if (ld || st) begin
            if (dd >= int'(WAIT_MAX)) begin
                e.p4 = int'(WAIT_MAX);
                e.req += int'(WAIT_MAX);
                e.we = st ? int'(WAIT_MAX) : 0;
                e.kind = 2;
                return e;
            end
            e.p4 = dd + 1;
            e.req += dd + 1;
            e.we = st ? dd + 1 : 0;
        end else begin
`ifdef PHASE_SKIP_EN
            e.p4 = 0;
`else
            e.p4 = 1;
`endif
        end
        e.p5 = 1;
        e.rf = (ld || (alu && op != 5 && op != 13)) ? 1 : 0;
        e.kind = 0;
        return e;
    endfunction

    // Monitor: accumulate one instruction's activity, compare when it ends
    bit       in_txn = 1'b0;
    logic [4:0] prev_phase = 5'b0;
    int       pc [5];
    int       c_szcv, c_rf, c_req, c_we, c_irl;

    task automatic finish_txn(input int kind);
        exp_t e;
        in_txn = 1'b0;
        completed++;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("p1_cycles", pc[0], e.p1);
        chk("p2_cycles", pc[1], e.p2);
        chk("p3_cycles", pc[2], e.p3);
        chk("p4_cycles", pc[3], e.p4);
        chk("p5_cycles", pc[4], e.p5);
        chk("szcv_we_cycles", c_szcv, e.szcv);
        chk("rf_we_cycles", c_rf, e.rf);
        chk("mem_req_cycles", c_req, e.req);
        chk("mem_we_cycles", c_we, e.we);
        chk("ir_load_cycles", c_irl, e.irl);
        chk("end_kind", kind, e.kind);
        chk("retired", int'(retired), e.ret);
    endtask

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            in_txn     = 1'b0;
            prev_phase = 5'b0;
        end else begin
            if (phase == 5'b00001 && prev_phase != 5'b00001) begin
                if (in_txn) chk("txn_overrun", 1, 0);
                in_txn = 1'b1;
                for (int k = 0; k < 5; k++) pc[k] = 0;
                c_szcv = 0; c_rf = 0; c_req = 0; c_we = 0; c_irl = 0;
                chk("bus_err_at_fetch", int'(bus_err), 0);
                chk("halted_at_fetch", int'(halted), 0);
            end
            if (in_txn) begin
                if (phase != 5'b0) begin
                    chk("phase_onehot", $countones(phase), 1);
                    for (int k = 0; k < 5; k++) if (phase[k]) pc[k]++;
                    c_szcv += int'(szcv_we);
                    c_rf   += int'(rf_we);
                    c_req  += int'(mem_req);
                    c_we   += int'(mem_we);
                    c_irl  += int'(ir_load);
                    if (pc_we) finish_txn(0);
                end else begin
                    finish_txn(!halted ? 3 : (bus_err ? 2 : 1));
                end
            end
            prev_phase = phase;
        end
    end

    // Driver: starts, instruction/ack-delay choice, handshake responses
    initial begin : driver
        int   cyc;
        int   cnt;
        int   fd;
        int   dd;
        int   dly;
        int   model_ret;
        bit   seen_p1;
        logic [15:0] w;
        rst_n = 1'b0; start = 1'b0; instr = '0; mem_ack = 1'b0;
        cyc = 0; cnt = 0; fd = 0; dd = 0; model_ret = 0; seen_p1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_strobes", int'({mem_we, ir_load, szcv_we, rf_we, pc_we}), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_bus_err", int'(bus_err), 0);
        chk("rst_retired", int'(retired), 0);
        rst_n = 1'b1;
        while (completed < N_TX && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (phase == 5'b00001 && !seen_p1) begin
                w  = pick_instr();
                fd = pick_delay();
                dd = pick_delay();
                instr = w;
                exp_q.push_back(model(w, fd, dd, model_ret));
                if (exp_q[$].kind == 0) model_ret = (model_ret + 1) % (1 << CNT_W);
            end
            seen_p1 = (phase == 5'b00001);
            if (mem_req) begin
                dly     = phase[0] ? fd : dd;
                mem_ack = (cnt == dly);
                cnt     = mem_ack ? 0 : cnt + 1;
            end else begin
                cnt     = 0;
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            if (phase == 5'b0) start = ($urandom_range(0, 2) == 0);
            else               start = ($urandom_range(0, 7) == 0);
        end
        if (completed < N_TX) chk("run_budget", completed, N_TX);

        // Asynchronous reset in the middle of an outstanding memory access
        mem_ack = 1'b0;
        start   = 1'b1;
        cyc     = 0;
        while (!mem_req && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mem_req_before_reset", int'(mem_req), 1);
        #2;
        abort = 1'b1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_phase", int'(phase), 0);
        chk("midrst_mem_req", int'(mem_req), 0);
        chk("midrst_strobes", int'({mem_we, ir_load, szcv_we, rf_we, pc_we}), 0);
        chk("midrst_halted", int'(halted), 0);
        chk("midrst_bus_err", int'(bus_err), 0);
        chk("midrst_retired", int'(retired), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_phase", int'(phase), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
